// File: rtl/instr_mem_loadable.sv
// Run-time loadable instruction RAM: streaming load port, registered fetch with range check.
// Latency: fetch data/instr_valid/pc_err one cycle after fetch_en; one load word per cycle.
// Backpressure: load_ready high only in LOAD; fetches outside READY are ignored. Option: IRAM_PARITY_EN.
module instr_mem_loadable #(
    parameter int INSTR_W = 20,
    parameter int ADDR_W  = 6,
    parameter int DEPTH   = 46
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_start,
    input  logic                load_valid,
    input  logic [INSTR_W-1:0]  load_data,
    input  logic                load_last,
    output logic                load_ready,
    output logic                load_done,
    output logic [ADDR_W:0]     load_count,
    input  logic                fetch_en,
    input  logic [ADDR_W-1:0]   pc,
    output logic [INSTR_W-1:0]  instr_out,
    output logic                instr_valid,
`ifdef IRAM_PARITY_EN
    output logic                parity_err,
`endif
    output logic                pc_err
);

    typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   wptr;
    logic [INSTR_W-1:0]  mem [DEPTH];

    // A restart in the same cycle discards the offered word.
    logic wr_en;
    logic in_range;
    logic fetch_go;
    assign wr_en      = (state == LOAD) && load_valid && !load_start;
    assign in_range   = {1'b0, pc} < load_count;
    assign fetch_go   = (state == READY) && fetch_en && !load_start;
    assign load_ready = (state == LOAD);

`ifdef IRAM_PARITY_EN
    logic                par_mem [DEPTH];
    logic                hook_pend;
    logic [ADDR_W-1:0]   hook_addr;

    // Track a just-written final word so a restart right after it can corrupt its parity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hook_pend <= 1'b0;
            hook_addr <= '0;
        end else begin
            hook_pend <= wr_en && load_last;
            hook_addr <= wptr;
        end
    end

    // Parity storage: even parity on write, inverted by the test hook.
    always_ff @(posedge clk) begin
        if (wr_en)
            par_mem[wptr] <= ^load_data;
        else if (hook_pend && load_start)
            par_mem[hook_addr] <= ~par_mem[hook_addr];
    end
`endif

    // Program store write port; no reset, contents unreachable until reloaded.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wptr] <= load_data;
    end

    // Load/run state machine with registered fetch outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            wptr        <= '0;
            load_count  <= '0;
            load_done   <= 1'b0;
            instr_out   <= '0;
            instr_valid <= 1'b0;
            pc_err      <= 1'b0;
`ifdef IRAM_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            load_done   <= 1'b0;
            instr_valid <= 1'b0;
            case (state)
                EMPTY: begin
                    if (load_start) begin
                        state      <= LOAD;
                        wptr       <= '0;
                        load_count <= '0;
                    end
                end
                LOAD: begin
                    if (load_start) begin
                        wptr       <= '0;
                        load_count <= '0;
                    end else if (load_valid) begin
                        wptr       <= wptr + ADDR_W'(1);
                        load_count <= load_count + (ADDR_W+1)'(1);
                        if (load_last || (wptr == ADDR_W'(DEPTH-1))) begin
                            state     <= READY;
                            load_done <= 1'b1;
                        end
                    end
                end
                READY: begin
                    if (load_start) begin
                        state      <= LOAD;
                        wptr       <= '0;
                        load_count <= '0;
                    end else if (fetch_go) begin
                        instr_valid <= 1'b1;
                        if (in_range) begin
                            instr_out <= mem[pc];
                            pc_err    <= 1'b0;
`ifdef IRAM_PARITY_EN
                            parity_err <= par_mem[pc] != (^mem[pc]);
`endif
                        end else begin
                            instr_out <= '0;
                            pc_err    <= 1'b1;
`ifdef IRAM_PARITY_EN
                            parity_err <= 1'b0;
`endif
                        end
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench for instr_mem_loadable: load, fetch, range, full, restart, collision, async reset.
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
// Expected values are hand-computed constants or the word_of() pattern for the full load.
module tb_instr_mem_loadable;

    localparam int INSTR_W = 20;
    localparam int ADDR_W  = 6;
    localparam int DEPTH   = 46;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               load_start, load_valid, load_last;
    logic [INSTR_W-1:0] load_data;
    logic               load_ready, load_done;
    logic [ADDR_W:0]    load_count;
    logic               fetch_en;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr_out;
    logic               instr_valid, pc_err;
`ifdef IRAM_PARITY_EN
    logic               parity_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_mem_loadable #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
        .load_count(load_count), .fetch_en(fetch_en), .pc(pc),
        .instr_out(instr_out), .instr_valid(instr_valid),
`ifdef IRAM_PARITY_EN
        .parity_err(parity_err),
`endif
        .pc_err(pc_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [INSTR_W-1:0] word_of(input int i);
        return INSTR_W'(32'h10000 + 3 * i);
    endfunction

    task automatic fetch(input int a);
        fetch_en = 1'b1;
        pc       = ADDR_W'(a);
        tick();
        fetch_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; load_start = 0; load_valid = 0; load_last = 0;
        load_data = '0; fetch_en = 0; pc = '0;
        #12;
        chk("rst_load_ready", load_ready, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_load_count", load_count, 0);
        chk("rst_instr_out", instr_out, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_pc_err", pc_err, 0);
        #3 rst_n = 1'b1;
        tick();

        // Fetch in EMPTY is ignored.
        fetch(0);
        chk("empty_fetch_valid", instr_valid, 0);

        // Three-word load.
        load_start = 1; tick(); load_start = 0;
        chk("load_ready_on", load_ready, 1);
        chk("load_count_clr", load_count, 0);
        load_valid = 1; load_data = 20'h31000; tick();
        chk("count_1", load_count, 1);
        load_data = 20'h32400; tick();
        load_data = 20'h33800; load_last = 1; tick();
        load_valid = 0; load_last = 0;
        chk("done3_pulse", load_done, 1);
        chk("count_3", load_count, 3);
        chk("ready_off3", load_ready, 0);
        tick();
        chk("done3_low", load_done, 0);

        fetch(1);
        chk("f1_data", instr_out, 32'h32400);
        chk("f1_err", pc_err, 0);
        chk("f1_valid", instr_valid, 1);
        fetch(5);
        chk("f5_data", instr_out, 0);
        chk("f5_err", pc_err, 1);
        chk("f5_valid", instr_valid, 1);
        tick();
        chk("idle_valid", instr_valid, 0);
        chk("idle_err_hold", pc_err, 1);

        // Back-to-back fetches.
        fetch_en = 1; pc = 0; tick();
        chk("b2b0_data", instr_out, 32'h31000);
        chk("b2b0_valid", instr_valid, 1);
        pc = 1; tick();
        chk("b2b1_data", instr_out, 32'h32400);
        chk("b2b1_valid", instr_valid, 1);
        pc = 2; tick();
        chk("b2b2_data", instr_out, 32'h33800);
        chk("b2b2_valid", instr_valid, 1);
        fetch_en = 0;

        // Full load with one gap, no load_last.
        load_start = 1; tick(); load_start = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 10) begin
                load_valid = 0; tick();
                chk("gap_count", load_count, 10);
            end
            load_valid = 1; load_data = word_of(i); tick();
            if (i == DEPTH - 2) chk("full_not_done", load_done, 0);
        end
        chk("full_done", load_done, 1);
        chk("full_count", load_count, DEPTH);
        chk("full_ready", load_ready, 0);
        load_data = 20'hFFFFF; tick();
        load_valid = 0;
        chk("full_no_accept", load_count, DEPTH);
        fetch(45);
        chk("f45_data", instr_out, 32'(word_of(45)));
        chk("f45_err", pc_err, 0);
        fetch(46);
        chk("f46_err", pc_err, 1);
        chk("f46_data", instr_out, 0);
        fetch(0);
        chk("f0_full_data", instr_out, 32'(word_of(0)));

        // Restart mid-load; the word offered with load_start is dropped.
        load_start = 1; tick(); load_start = 0;
        load_valid = 1; load_data = 20'h11111; tick();
        load_data = 20'h22222; tick();
        chk("restart_pre_count", load_count, 2);
        load_start = 1; load_data = 20'hAAAAA; tick(); load_start = 0;
        chk("restart_count", load_count, 0);
        chk("restart_ready", load_ready, 1);
        load_data = 20'h0BEEF; load_last = 1; tick();
        load_valid = 0; load_last = 0;
        chk("restart_done", load_done, 1);
        chk("restart_count1", load_count, 1);
        fetch(1);
        chk("restart_f1_err", pc_err, 1);
        fetch(0);
        chk("restart_f0_data", instr_out, 32'h0BEEF);
        chk("restart_f0_err", pc_err, 0);

        // Load wins over a simultaneous fetch.
        load_start = 1; fetch_en = 1; pc = 0; tick();
        load_start = 0; fetch_en = 0;
        chk("coll_valid", instr_valid, 0);
        chk("coll_state_load", load_ready, 1);

        // Asynchronous reset between edges during LOAD.
        load_valid = 1; load_data = 20'h55555; tick();
        load_valid = 0;
        chk("prearst_count", load_count, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_ready", load_ready, 0);
        chk("arst_count", load_count, 0);
        chk("arst_instr_out", instr_out, 0);
        chk("arst_pc_err", pc_err, 0);
        chk("arst_valid", instr_valid, 0);
        #2 rst_n = 1'b1;
        tick();
        fetch(0);
        chk("post_arst_fetch", instr_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
